idex_pipe_stage: RTL

Parametrised ID/EX pipeline stage for the MIPS datapath, replacing the bare always-load register.
- Adds a valid/ready elastic handshake with a one-entry skid buffer, so a stall from EX never drops or duplicates an instruction.
- Adds a synchronous flush for branch/jump kill, bubble insertion with zeroed control fields, and a saturating stall counter for performance monitoring.
- Sits between the ID decode/register-file read stage and the EX ALU stage.

---
 rtl/idex_pkg.sv | 34 +++
 rtl/idex_pipe_stage_if.sv | 52 +++++
 rtl/idex_pipe_stage_skid_slot.sv | 41 ++++
 rtl/idex_pipe_stage.sv | 101 ++++++++++
 4 files changed

// File: rtl/idex_pkg.sv
// rtl/idex_pkg.sv - default widths, EX-field bit positions and payload typedefs for the ID/EX stage
package idex_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RA_W_DEF    = 5;
    localparam int WB_W_DEF    = 2;
    localparam int M_W_DEF     = 3;
    localparam int ALUOP_W_DEF = 3;
    localparam int CNT_W_DEF   = 16;

    localparam int REGDST_BIT  = 0;
    localparam int ALUOP_LSB   = 1;
    localparam int ALUSRC_BIT  = ALUOP_W_DEF + 1;

    // Packed MSB-first so a raw EX vector casts directly: bit0 RegDst, top bit ALUSrc.
    typedef struct packed {
        logic                   alusrc;
        logic [ALUOP_W_DEF-1:0] aluop;
        logic                   regdst;
    } ex_ctrl_t;

    typedef struct packed {
        logic [WB_W_DEF-1:0] wb;
        logic [M_W_DEF-1:0]  m;
        ex_ctrl_t            ex;
        logic [XLEN_DEF-1:0] pc4;
        logic [XLEN_DEF-1:0] br1;
        logic [XLEN_DEF-1:0] br2;
        logic [XLEN_DEF-1:0] se;
        logic [RA_W_DEF-1:0] ins1;
        logic [RA_W_DEF-1:0] ins2;
    } idex_payload_t;

endpackage

// File: rtl/idex_pipe_stage_if.sv
// rtl/idex_pipe_stage_if.sv - ID/EX handshake and payload bundle; master is the ID/EX environment, slave is the stage
interface idex_pipe_stage_if
    import idex_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RA_W    = RA_W_DEF,
    parameter int WB_W    = WB_W_DEF,
    parameter int M_W     = M_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WB_W-1:0]    WB1;
    logic [M_W-1:0]     M1;
    logic [ALUOP_W+1:0] EX;
    logic [XLEN-1:0]    fPC4;
    logic [XLEN-1:0]    fBR1;
    logic [XLEN-1:0]    fBR2;
    logic [XLEN-1:0]    fSE;
    logic [RA_W-1:0]    fIns1;
    logic [RA_W-1:0]    fIns2;

    logic               out_valid;
    logic               out_ready;
    logic [WB_W-1:0]    Wb1;
    logic [M_W-1:0]     Mem1;
    logic               RegDst;
    logic [ALUOP_W-1:0] ALUOp;
    logic               ALUSrc;
    logic [XLEN-1:0]    tAdd;
    logic [XLEN-1:0]    tALU;
    logic [XLEN-1:0]    tMux32;
    logic [XLEN-1:0]    tACsl;
    logic [RA_W-1:0]    tMux5_1;
    logic [RA_W-1:0]    tMux5_2;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output flush, in_valid, WB1, M1, EX, fPC4, fBR1, fBR2, fSE, fIns1, fIns2, out_ready,
        input  in_ready, out_valid, Wb1, Mem1, RegDst, ALUOp, ALUSrc,
               tAdd, tALU, tMux32, tACsl, tMux5_1, tMux5_2, stall_cnt
    );

    modport slave (
        input  flush, in_valid, WB1, M1, EX, fPC4, fBR1, fBR2, fSE, fIns1, fIns2, out_ready,
        output in_ready, out_valid, Wb1, Mem1, RegDst, ALUOp, ALUSrc,
               tAdd, tALU, tMux32, tACsl, tMux5_1, tMux5_2, stall_cnt
    );

endinterface

// File: rtl/idex_pipe_stage_skid_slot.sv
// rtl/idex_pipe_stage_skid_slot.sv - generic payload register with valid bit, load and clear
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Clear drops only the valid bit; the payload keeps its last loaded value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/idex_pipe_stage.sv
// rtl/idex_pipe_stage.sv - elastic ID/EX register with one-entry skid, flush, bubble gating and stall counter
module idex_pipe_stage
    import idex_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RA_W    = RA_W_DEF,
    parameter int WB_W    = WB_W_DEF,
    parameter int M_W     = M_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clkIDEX,
    input  logic               rstIDEX_n,
    idex_pipe_stage_if.slave   bus
);
    localparam int EX_W = ALUOP_W + 2;
    localparam int PW   = WB_W + M_W + EX_W + 4 * XLEN + 2 * RA_W;

    logic [PW-1:0]    in_pl, main_pl, skid_pl, main_d;
    logic             main_v, skid_v;
    logic             accept, main_free;
    logic             main_load, main_clr, skid_load, skid_clr;

    logic [WB_W-1:0]  wb_q;
    logic [M_W-1:0]   m_q;
    logic [EX_W-1:0]  ex_q;
    logic [XLEN-1:0]  pc4_q, br1_q, br2_q, se_q;
    logic [RA_W-1:0]  ins1_q, ins2_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_pl = {bus.WB1, bus.M1, bus.EX, bus.fPC4, bus.fBR1, bus.fBR2, bus.fSE,
                    bus.fIns1, bus.fIns2};

    // in_ready is the registered skid-empty flag, so out_ready never reaches it combinationally.
    assign accept    = bus.in_valid & ~skid_v;
    assign main_free = ~main_v | bus.out_ready;

    assign main_load = ~bus.flush & main_free & (skid_v | accept);
    assign main_clr  = bus.flush | (main_free & ~skid_v & ~accept);
    assign main_d    = skid_v ? skid_pl : in_pl;

    assign skid_load = ~bus.flush & accept & ~main_free;
    assign skid_clr  = bus.flush | (main_free & skid_v);

    pipe_skid_slot #(.W(PW)) u_main (
        .clk_i   (clkIDEX),
        .rst_ni  (rstIDEX_n),
        .load_i  (main_load),
        .clr_i   (main_clr),
        .d_i     (main_d),
        .valid_o (main_v),
        .q_o     (main_pl)
    );

    pipe_skid_slot #(.W(PW)) u_skid (
        .clk_i   (clkIDEX),
        .rst_ni  (rstIDEX_n),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .d_i     (in_pl),
        .valid_o (skid_v),
        .q_o     (skid_pl)
    );

    assign {wb_q, m_q, ex_q, pc4_q, br1_q, br2_q, se_q, ins1_q, ins2_q} = main_pl;

    assign bus.in_ready  = ~skid_v;
    assign bus.out_valid = main_v;

    // Control fields read as a bubble whenever the main register is empty.
    assign bus.Wb1    = main_v ? wb_q : '0;
    assign bus.Mem1   = main_v ? m_q  : '0;
    assign bus.RegDst = main_v & ex_q[REGDST_BIT];
    assign bus.ALUOp  = main_v ? ex_q[ALUOP_LSB +: ALUOP_W] : '0;
    assign bus.ALUSrc = main_v & ex_q[ALUOP_LSB + ALUOP_W];

    assign bus.tAdd    = pc4_q;
    assign bus.tALU    = br1_q;
    assign bus.tMux32  = br2_q;
    assign bus.tACsl   = se_q;
    assign bus.tMux5_1 = ins1_q;
    assign bus.tMux5_2 = ins2_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v && !bus.out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkIDEX) begin
        if (!rstIDEX_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;

endmodule
